// File: rtl/mau_pkg.sv
// Shared definitions for the data-memory access unit: size codes, FSM states
// and the alignment rule used when a request is accepted.
package mau_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_ILL  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RMW_RD,
        ST_WR,
        ST_RESP
    } state_e;

    // True when the size code is illegal or the byte offset does not suit the size
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Little-endian lane handling: pulls the addressed byte/half out of a memory
// word with sign or zero extension, and splices store data into an old word.
module mau_lane_align
    import mau_pkg::*;
(
    input  logic [31:0] rword_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [4:0]  shift;
    logic [15:0] shifted;
    logic [31:0] laneMask;
    logic [31:0] laneData;

    // Extract/extend the addressed lane for loads and build the merged word for stores
    always_comb begin
        shift    = {offset_i, 3'b000};
        shifted  = 16'(rword_i >> shift);
        laneMask = 32'h0;
        laneData = 32'h0;
        load_o   = rword_i;
        merge_o  = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                load_o   = {{24{signed_i & shifted[7]}}, shifted[7:0]};
                laneMask = 32'h0000_00FF << shift;
                laneData = {24'h0, wdata_i[7:0]} << shift;
                merge_o  = (rword_i & ~laneMask) | laneData;
            end
            SZ_HALF: begin
                load_o   = {{16{signed_i & shifted[15]}}, shifted};
                laneMask = 32'h0000_FFFF << shift;
                laneData = {16'h0, wdata_i[15:0]} << shift;
                merge_o  = (rword_i & ~laneMask) | laneData;
            end
            default: begin
                load_o  = rword_i;
                merge_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator side of the data-memory port: turns byte-addressed load/store
// requests into word read/write cycles, doing sub-word stores as
// read-modify-write and flagging misaligned or out-of-range accesses.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [1:0]    req_size,
    input  logic          req_signed,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic [31:0]   mem_address,
    output logic [31:0]   mem_writeData,
    input  logic [31:0]   mem_readData,
    output logic          mem_memRead,
    output logic          mem_memWrite
);

    localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

    state_e      state_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;
    logic [31:0] mem_address_q;
    logic [31:0] mem_writeData_q;
    logic        mem_memRead_q;
    logic        mem_memWrite_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [1:0]  offset_q;
    logic [31:0] wdata_q;

    logic        reqErr;
    logic [31:0] loadData;
    logic [31:0] mergeData;

    assign reqErr = misaligned(req_size, req_addr[1:0]) ||
                    ({2'b00, req_addr[AW-1:2]} >= DEPTH_W);

    mau_lane_align u_align (
        .rword_i  (mem_readData),
        .wdata_i  (wdata_q),
        .offset_i (offset_q),
        .size_i   (size_q),
        .signed_i (signed_q),
        .load_o   (loadData),
        .merge_o  (mergeData)
    );

    // Request FSM; every output is registered so mem_* never sees req_* combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            req_ready_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_err_q      <= 1'b0;
            resp_rdata_q    <= 32'h0;
            mem_address_q   <= 32'h0;
            mem_writeData_q <= 32'h0;
            mem_memRead_q   <= 1'b0;
            mem_memWrite_q  <= 1'b0;
            size_q          <= SZ_BYTE;
            signed_q        <= 1'b0;
            offset_q        <= 2'b00;
            wdata_q         <= 32'h0;
        end else begin
            resp_valid_q   <= 1'b0;
            resp_err_q     <= 1'b0;
            resp_rdata_q   <= 32'h0;
            mem_memRead_q  <= 1'b0;
            mem_memWrite_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_RESP: begin
                    if (req_valid) begin
                        size_q        <= req_size;
                        signed_q      <= req_signed;
                        offset_q      <= req_addr[1:0];
                        wdata_q       <= req_wdata;
                        mem_address_q <= 32'({2'b00, req_addr[AW-1:2]});
                        if (reqErr) begin
                            state_q      <= ST_RESP;
                            req_ready_q  <= 1'b1;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else if (!req_write) begin
                            state_q       <= ST_RD;
                            req_ready_q   <= 1'b0;
                            mem_memRead_q <= 1'b1;
                        end else if (req_size == SZ_WORD) begin
                            state_q         <= ST_WR;
                            req_ready_q     <= 1'b0;
                            mem_memWrite_q  <= 1'b1;
                            mem_writeData_q <= req_wdata;
                        end else begin
                            state_q       <= ST_RMW_RD;
                            req_ready_q   <= 1'b0;
                            mem_memRead_q <= 1'b1;
                        end
                    end else begin
                        state_q     <= ST_IDLE;
                        req_ready_q <= 1'b1;
                    end
                end
                ST_RD: begin
                    state_q      <= ST_RESP;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= loadData;
                end
                ST_RMW_RD: begin
                    state_q         <= ST_WR;
                    req_ready_q     <= 1'b0;
                    mem_memWrite_q  <= 1'b1;
                    mem_writeData_q <= mergeData;
                end
                ST_WR: begin
                    state_q      <= ST_RESP;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b1;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_err      = resp_err_q;
    assign resp_rdata    = resp_rdata_q;
    assign mem_address   = mem_address_q;
    assign mem_writeData = mem_writeData_q;
    assign mem_memRead   = mem_memRead_q;
    assign mem_memWrite  = mem_memWrite_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural data memory and a
// response scoreboard that also checks response latency.
module tb_mem_access_unit;

    localparam int DEPTH = 1024;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_writeData;
    logic [31:0] mem_readData;
    logic        mem_memRead;
    logic        mem_memWrite;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        int          id;
    } expResp_t;

    expResp_t    scoreboard[$];
    logic [31:0] memArr [0:DEPTH-1];
    int          cycleCount = 0;
    int          readCount  = 0;
    int          writeCount = 0;
    int          compared   = 0;
    int          mismatched = 0;
    int          nextId     = 0;

    mem_access_unit #(.DEPTH(DEPTH), .AW(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_size      (req_size),
        .req_signed    (req_signed),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .mem_address   (mem_address),
        .mem_writeData (mem_writeData),
        .mem_readData  (mem_readData),
        .mem_memRead   (mem_memRead),
        .mem_memWrite  (mem_memWrite)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter, stepped on every active edge
    always @(posedge clk) cycleCount++;

    // Memory reads settle combinationally from the held address
    assign mem_readData = (mem_address < 32'(DEPTH)) ? memArr[mem_address[9:0]] : 32'h0;

    // Memory commits writes on the falling edge
    always @(negedge clk) begin
        if (mem_memWrite && mem_address < 32'(DEPTH)) memArr[mem_address[9:0]] = mem_writeData;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Strobe bookkeeping and scoreboard popping, sampled away from the active edge
    always @(negedge clk) begin
        expResp_t e;
        if (mem_memRead)  readCount++;
        if (mem_memWrite) writeCount++;
        if (mem_memRead && mem_memWrite) checkOutput("strobe_excl", {30'h0, mem_memRead, mem_memWrite}, 32'h0);
        if (resp_valid) begin
            if (scoreboard.size() == 0) begin
                checkOutput("unexpected_resp", {31'h0, resp_valid}, 32'h0);
            end else begin
                e = scoreboard.pop_front();
                checkOutput($sformatf("rdata#%0d", e.id), resp_rdata, e.rdata);
                checkOutput($sformatf("err#%0d", e.id), {31'h0, resp_err}, {31'h0, e.err});
                checkOutput($sformatf("latency#%0d", e.id), cycleCount, e.cyc);
            end
        end
    end

    // Present one request, wait for acceptance, and record the expected response
    task automatic applyStimulus(input logic wr, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expRdata, input logic expErr,
                                 input int latency, input logic expectResp,
                                 output int acceptCycle);
        int guard = 0;
        expResp_t e;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) checkOutput("accept_timeout", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        req_valid   = 1'b0;
        acceptCycle = cycleCount;
        if (expectResp) begin
            e.rdata = expRdata;
            e.err   = expErr;
            e.cyc   = cycleCount + latency - 1;
            e.id    = nextId;
            scoreboard.push_back(e);
        end
        nextId++;
    endtask

    task automatic waitIdle();
        int guard = 0;
        while (scoreboard.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("drain", scoreboard.size(), 32'h0);
        @(negedge clk);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
        checkOutput({tag, "_rvalid"}, {31'h0, resp_valid}, 32'h0);
        checkOutput({tag, "_rerr"}, {31'h0, resp_err}, 32'h0);
        checkOutput({tag, "_rdata"}, resp_rdata, 32'h0);
        checkOutput({tag, "_strobes"}, {30'h0, mem_memRead, mem_memWrite}, 32'h0);
        checkOutput({tag, "_addr"}, mem_address, 32'h0);
        checkOutput({tag, "_wdata"}, mem_writeData, 32'h0);
    endtask

    initial begin
        int acc0;
        int acc1;
        int rd0;
        int wr0;
        for (int i = 0; i < DEPTH; i++) memArr[i] = 32'h0;
        memArr[2]  = 32'd100;
        memArr[3]  = 32'hFFFF_FE0C;
        memArr[4]  = 32'd300;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        #12;
        checkResetOutputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Word load from word 2
        rd0 = readCount;
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 32'd100, 1'b0, 2, 1'b1, acc0);
        checkOutput("ld_addr", mem_address, 32'd2);
        checkOutput("ld_read", {31'h0, mem_memRead}, 32'h1);
        waitIdle();
        checkOutput("ld_read_cycles", readCount - rd0, 32'd1);

        // Byte store into word 3 via read-modify-write
        rd0 = readCount;
        wr0 = writeCount;
        applyStimulus(1'b1, 2'd0, 1'b0, 32'hD, 32'h0000_00AB, 32'h0, 1'b0, 3, 1'b1, acc0);
        @(posedge clk);
        #1;
        checkOutput("rmw_wstrobe", {31'h0, mem_memWrite}, 32'h1);
        checkOutput("rmw_wdata", mem_writeData, 32'hFFFF_AB0C);
        waitIdle();
        checkOutput("rmw_reads", readCount - rd0, 32'd1);
        checkOutput("rmw_writes", writeCount - wr0, 32'd1);
        checkOutput("rmw_mem", memArr[3], 32'hFFFF_AB0C);

        // Sub-word loads with sign and zero extension
        applyStimulus(1'b0, 2'd1, 1'b1, 32'hE, 32'h0, 32'hFFFF_FFFF, 1'b0, 2, 1'b1, acc0);
        applyStimulus(1'b0, 2'd1, 1'b0, 32'hE, 32'h0, 32'h0000_FFFF, 1'b0, 2, 1'b1, acc0);
        applyStimulus(1'b0, 2'd0, 1'b1, 32'hD, 32'h0, 32'hFFFF_FFAB, 1'b0, 2, 1'b1, acc0);
        applyStimulus(1'b0, 2'd0, 1'b0, 32'hC, 32'h0, 32'h0000_000C, 1'b0, 2, 1'b1, acc0);
        waitIdle();

        // Error cases never touch memory
        rd0 = readCount;
        wr0 = writeCount;
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 32'h0, 1'b1, 1, 1'b1, acc0);
        applyStimulus(1'b1, 2'd1, 1'b0, 32'h11, 32'h1234, 32'h0, 1'b1, 1, 1'b1, acc0);
        applyStimulus(1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1, 1'b1, acc0);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1, 1, 1'b1, acc0);
        waitIdle();
        checkOutput("err_reads", readCount - rd0, 32'd0);
        checkOutput("err_writes", writeCount - wr0, 32'd0);

        // Reset during the write cycle of a word store to word 4
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h10, 32'h1234_5678, 32'h0, 1'b0, 2, 1'b0, acc0);
        checkOutput("wr_strobe_pre", {31'h0, mem_memWrite}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("midrst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midrst_mem", memArr[4], 32'd300);

        // Store then load the same word with the load accepted during RESP
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h14, 32'hCAFE_F00D, 32'h0, 1'b0, 2, 1'b1, acc0);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 32'hCAFE_F00D, 1'b0, 2, 1'b1, acc1);
        checkOutput("b2b_gap", acc1 - acc0, 32'd2);
        waitIdle();
        checkOutput("b2b_mem", memArr[5], 32'hCAFE_F00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory port. Sits between the MEM pipeline stage and the word-addressed data memory.
- Converts byte-addressed load/store requests (byte, half, word; signed or unsigned loads) into word-level memory read/write cycles.
- Sub-word stores are done as read-modify-write (RMW).
- Flags misaligned and out-of-range accesses and raises a ready/stall handshake toward the pipeline.

Parameters:
- DEPTH, 1024, number of 32-bit words in the attached data memory. Word index >= DEPTH is out of range.
- AW, 32, byte-address width of req_addr and mem_address.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  pipeline presents a request.
- req_ready  out  1  unit can accept a request this cycle. Pipeline stalls while req_valid && !req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_signed  in  1  sign-extend loads (ignored for stores).
- req_addr  in  AW  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle pulse: request complete.
- resp_rdata  out  32  extended load data, valid with resp_valid. 0 for stores and errors.
- resp_err  out  1  valid with resp_valid: misaligned, illegal size, or out of range.
- mem_address  out  32  word index, equal to req_addr >> 2.
- mem_writeData  out  32  word to write.
- mem_readData  in  32  word read; settles within the cycle mem_address/mem_memRead are held.
- mem_memRead  out  1  read strobe.
- mem_memWrite  out  1  write strobe; memory commits on negedge clk while high.

Behaviour:
- Reset (async, immediate):
  - state = IDLE; req_ready = 1.
  - resp_valid, resp_err, mem_memRead, mem_memWrite = 0.
  - resp_rdata, mem_address, mem_writeData = 0.
- States: IDLE, RD, RMW_RD, WR, RESP.
- Accept rule: a request is accepted on a posedge where req_valid && req_ready. req_ready = 1 only in IDLE and RESP. On accept, addr/size/signed/wdata/write are latched.
- Transitions from the accept cycle:
  - error (size 3; half with addr[0] = 1; word with addr[1:0] != 0; addr[AW-1:2] >= DEPTH) -> RESP with err = 1. No memory strobe is ever asserted.
  - load -> RD.
  - word store -> WR.
  - byte/half store -> RMW_RD.
- RD: mem_memRead = 1 with mem_address held; mem_readData captured at the cycle end -> RESP.
- RMW_RD: same read; the captured word is merged with the latched data into the selected lane(s) -> WR.
- WR: mem_memWrite = 1 for exactly one cycle with mem_writeData = merged or full word -> RESP.
- RESP: resp_valid = 1 for one cycle. If a new request is accepted, branch as from IDLE; otherwise -> IDLE.
- Latency from accept edge to resp_valid:
  - error: 1 cycle.
  - load: 2 cycles.
  - word store: 2 cycles.
  - sub-word store: 3 cycles.
- Back-to-back throughput: one request per 2/2/3 cycles respectively.
- Lane order is little-endian: byte offset 0 = bits [7:0]; half offset 2 = bits [31:16].
- Load extension: signed replicates the MSB of the lane; unsigned zero-fills.
- All mem_* outputs come from state and latched registers only. There is no combinational path from req_* to mem_*.
- mem_memRead and mem_memWrite are never high together; outside RD/RMW_RD/WR both are 0.
- Reset mid-operation: strobes drop asynchronously. Reset during WR before the negedge means no write occurs. The pending response is discarded and no resp_valid is issued.

Decomposition:
- Package mau_pkg: size codes (SZ_BYTE, SZ_HALF, SZ_WORD), state enum, and a function for alignment checking.
- Sub-module mau_lane_align (combinational): extract plus sign/zero-extend for loads, and lane merge for stores. Instantiated once.

Test Plan:
1. Word 2 = 100; load word, addr 0x8 -> mem_address = 2, mem_memRead high one cycle; resp_valid 2 cycles after accept with resp_rdata = 100, resp_err = 0.
2. Word 3 = 0xFFFFFE0C; store byte 0xAB at 0x0D -> one RMW read, then one mem_memWrite cycle with 0xFFFFAB0C; resp_valid at +3; word 3 = 0xFFFFAB0C.
3. Then:
   - signed half load 0x0E -> 0xFFFFFFFF.
   - unsigned half load 0x0E -> 0x0000FFFF.
   - signed byte load 0x0D -> 0xFFFFFFAB.
   - unsigned byte load 0x0C -> 0x0000000C.
4. Error cases, each -> resp_valid at +1 with resp_err = 1 and both strobes 0 throughout:
   - word load 0x6.
   - half store 0x11.
   - size 3.
   - load 0x1000 (word 1024).
5. Assert rst_n low during WR before negedge of a word store of 0x12345678 to word 4 (old 300) -> strobes drop immediately; word 4 stays 300; no resp_valid; all outputs at reset values.
6. Request held valid during RESP: word store then load to the same address -> second accept in the RESP cycle; load returns the stored value; no idle cycle between.
